// File: rtl/wave_meas.sv
// wave_meas: hysteresis crossing detector measuring period and peak-to-peak per rising crossing.
// Define WAVE_MEAS_AVG_EN to add a running mean over the last 4 periods.
module wave_meas #(
  parameter logic [7:0]       MID     = 8'd128,
  parameter logic [7:0]       HYST    = 8'd16,
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] TIMEOUT = 24'hFF_FFFF
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [7:0]       i_wave,
  input  logic             i_valid,
  output logic [CNT_W-1:0] o_period,
  output logic [7:0]       o_pp,
  output logic             o_meas_vld,
  output logic             o_locked,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_avg_period,
  output logic             o_avg_vld
);
  typedef enum logic [1:0] {S_INIT, S_LOW, S_HIGH} state_t;
  localparam logic [CNT_W-1:0] CMAX = '1;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, period_q, period_d;
  logic [7:0]       min_q, min_d, max_q, max_d, pp_q, pp_d;
  logic             locked_q, locked_d, meas_q, meas_d, tmo_q, tmo_d;
  logic             hi, lo, rise;
  // 9-bit compares keep MID+HYST and MID-HYST from wrapping
  assign hi      = {1'b0, i_wave} >= {1'b0, MID} + {1'b0, HYST};
  assign lo      = {1'b0, i_wave} + {1'b0, HYST} <= {1'b0, MID};
  assign rise    = i_valid && hi && state_q == S_LOW;
  assign cnt_inc = cnt_q == CMAX ? cnt_q : cnt_q + 1'b1;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    min_d    = min_q;
    max_d    = max_q;
    locked_d = locked_q;
    period_d = period_q;
    pp_d     = pp_q;
    meas_d   = 1'b0;
    tmo_d    = 1'b0;
    if (i_valid) begin
      state_d = hi ? S_HIGH : lo ? S_LOW : state_q;
      cnt_d   = rise ? '0 : cnt_inc;
      min_d   = rise || i_wave < min_q ? i_wave : min_q;
      max_d   = rise || i_wave > max_q ? i_wave : max_q;
      if (rise) begin
        locked_d = 1'b1;
        meas_d   = locked_q;
        period_d = locked_q ? cnt_inc : period_q;
        pp_d     = locked_q ? max_q - min_q : pp_q;
      end else if (locked_q && cnt_d == TIMEOUT) begin
        locked_d = 1'b0;
        tmo_d    = 1'b1;
      end
    end
  end
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      min_q    <= 8'hFF;
      max_q    <= 8'h00;
      locked_q <= 1'b0;
      period_q <= '0;
      pp_q     <= '0;
      meas_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      min_q    <= min_d;
      max_q    <= max_d;
      locked_q <= locked_d;
      period_q <= period_d;
      pp_q     <= pp_d;
      meas_q   <= meas_d;
      tmo_q    <= tmo_d;
    end
  end
  assign o_period   = period_q;
  assign o_pp       = pp_q;
  assign o_meas_vld = meas_q;
  assign o_locked   = locked_q;
  assign o_timeout  = tmo_q;
`ifdef WAVE_MEAS_AVG_EN
  logic [CNT_W-1:0] hist_q [3], hist_d [3], avg_q, avg_d;
  logic [2:0]       hcnt_q, hcnt_d;
  logic             avg_vld_q, avg_vld_d;
  logic [CNT_W+1:0] sum;
  assign sum = {2'b0, cnt_inc} + {2'b0, hist_q[0]} + {2'b0, hist_q[1]} + {2'b0, hist_q[2]};
  always_comb begin
    hist_d    = hist_q;
    hcnt_d    = hcnt_q;
    avg_d     = avg_q;
    avg_vld_d = 1'b0;
    if (tmo_d) begin
      hist_d = '{default: '0};
      hcnt_d = '0;
    end else if (meas_d) begin
      hist_d    = '{cnt_inc, hist_q[0], hist_q[1]};
      hcnt_d    = hcnt_q == 3'd4 ? hcnt_q : hcnt_q + 3'd1;
      avg_vld_d = hcnt_q >= 3'd3;
      avg_d     = hcnt_q >= 3'd3 ? sum[CNT_W+1:2] : avg_q;
    end
  end
  always_ff @(posedge sclk) begin
    if (rst) begin
      hist_q    <= '{default: '0};
      hcnt_q    <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      hcnt_q    <= hcnt_d;
      avg_q     <= avg_d;
      avg_vld_q <= avg_vld_d;
    end
  end
  assign o_avg_period = avg_q;
  assign o_avg_vld    = avg_vld_q;
`else
  assign o_avg_period = '0;
  assign o_avg_vld    = 1'b0;
`endif
endmodule
